// File: rtl/nos_frame_if.sv
// Parallel PCM frame handshake between the I2S deserializer and the NOS serializer.
// The producer holds in_data/in_valid; a frame transfers on a clk edge with in_valid && in_ready.
interface nos_frame_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned IN_WIDTH = 32
);
  logic [CHANNELS*IN_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/nos_multi_serializer.sv
// NOS DAC output serializer: frame FIFO feeding CHANNELS MSB-first data lines
// with a shared bit clock and a latch-enable strobe after each frame.
module nos_multi_serializer #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned IN_WIDTH     = 32,
  parameter int unsigned MAX_OUT_BITS = 24,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BCK_DIV      = 2,
  localparam int unsigned LenW        = $clog2(MAX_OUT_BITS + 1),
  localparam int unsigned LvlW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  nos_frame_if.slave          frame,
  input  logic [LenW-1:0]     out_bits,
  input  logic                bck_cont,
  input  logic                enable,
  output logic                bck,
  output logic [CHANNELS-1:0] data,
  output logic                le,
  output logic                underrun,
  output logic [LvlW-1:0]     fifo_level
);

  localparam int unsigned FrameW = CHANNELS * IN_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned LatW   = $clog2(2 * BCK_DIV);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StLatch} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  bck_q, bck_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [LenW-1:0]       bit_q, bit_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic                  le_q, le_d;
  logic                  und_q, und_d;
  logic [CHANNELS-1:0]   data_q, data_d;
  logic [IN_WIDTH-1:0]   sreg_q [CHANNELS];
  logic [IN_WIDTH-1:0]   sreg_d [CHANNELS];

  logic [FrameW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LvlW-1:0]       lvl_q, lvl_d;
  logic                  rdy_q, rdy_d;

  logic                  push, pop, empty, run, wrap, fall;
  logic [FrameW-1:0]     head;
  logic [IN_WIDTH-1:0]   word;

  assign push  = frame.in_valid & rdy_q;
  assign empty = (lvl_q == '0);
  assign head  = mem_q[rd_q];

  // Phase counter runs in SHIFT always; in IDLE/LATCH only in continuous mode.
  // LOAD keeps running while bck is high so a pending fall is never cut short.
  always_comb begin
    unique case (state_q)
      StShift: run = 1'b1;
      StLoad:  run = bck_cont | bck_q;
      default: run = bck_cont;
    endcase
    wrap = (cnt_q == CntW'(BCK_DIV - 1));
    fall = run & wrap & bck_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bck_d   = bck_q;
    len_d   = len_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    le_d    = le_q;
    und_d   = 1'b0;
    data_d  = data_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;
    word    = '0;

    if (run) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
      bck_d = wrap ? ~bck_q : bck_q;
    end else begin
      cnt_d = '0;
      bck_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        data_d = '0;
        le_d   = 1'b0;
        if (!empty && enable) state_d = StLoad;
      end
      // The pop always lands on a bck fall (cont) or with bck parked low (stop),
      // so the phase counter restarts from zero either way.
      StLoad: begin
        if (fall || (!bck_q && !bck_cont)) begin
          pop   = 1'b1;
          bit_d = '0;
          if (out_bits == '0 || out_bits > LenW'(MAX_OUT_BITS)) len_d = LenW'(MAX_OUT_BITS);
          else                                                  len_d = out_bits;
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            word      = head[k*IN_WIDTH +: IN_WIDTH];
            data_d[k] = word[IN_WIDTH-1];
            sreg_d[k] = {word[IN_WIDTH-2:0], 1'b0};
          end
          state_d = StShift;
        end
      end
      StShift: begin
        if (fall) begin
          if (bit_q == len_q - LenW'(1)) begin
            data_d  = '0;
            le_d    = 1'b1;
            lat_d   = '0;
            state_d = StLatch;
          end else begin
            bit_d = bit_q + LenW'(1);
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              data_d[k] = sreg_q[k][IN_WIDTH-1];
              sreg_d[k] = {sreg_q[k][IN_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      StLatch: begin
        if (lat_q == LatW'(2 * BCK_DIV - 1)) begin
          le_d = 1'b0;
          if (!empty && enable) begin
            state_d = StLoad;
          end else begin
            state_d = StIdle;
            und_d   = enable & empty;
          end
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_d = push ? wr_q + PtrW'(1) : wr_q;
    rd_d = pop  ? rd_q + PtrW'(1) : rd_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LvlW'(1);
      2'b01:   lvl_d = lvl_q - LvlW'(1);
      default: lvl_d = lvl_q;
    endcase
    rdy_d = (lvl_d != LvlW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bck_q   <= 1'b0;
      len_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      le_q    <= 1'b0;
      und_q   <= 1'b0;
      data_q  <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) sreg_q[k] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bck_q   <= bck_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      le_q    <= le_d;
      und_q   <= und_d;
      data_q  <= data_d;
      sreg_q  <= sreg_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      rdy_q   <= rdy_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= frame.in_data;
  end

  assign frame.in_ready = rdy_q;
  assign bck            = bck_q;
  assign data           = data_q;
  assign le             = le_q;
  assign underrun       = und_q;
  assign fifo_level     = lvl_q;

endmodule

// File: tb/tb_nos_multi_serializer.sv
// Directed bench for nos_multi_serializer: a vector table of single frames plus
// hand sequences for latency, back-to-back, full FIFO, continuous BCK and reset.
module tb_nos_multi_serializer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] out_bits;
  logic       bck_cont, enable;
  logic       bck, le, underrun;
  logic [1:0] data;
  logic [2:0] fifo_level;

  nos_frame_if #(.CHANNELS(2), .IN_WIDTH(32)) fr ();

  nos_multi_serializer #(
    .CHANNELS(2), .IN_WIDTH(32), .MAX_OUT_BITS(24), .FIFO_DEPTH(4), .BCK_DIV(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame     (fr),
    .out_bits  (out_bits),
    .bck_cont  (bck_cont),
    .enable    (enable),
    .bck       (bck),
    .data      (data),
    .le        (le),
    .underrun  (underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor, sampled on the falling clk edge.
  int          cyc = 0, last_rise = -1, le_fall_cyc = 0;
  int          rises, le_rises, le_falls, le_cycles, und_cnt;
  int          hi_change_err, le_align_err, cont_align_err, per_err, gap_max, gap_cnt;
  bit          gap_armed, freeze, freeze_on_le;
  logic [63:0] cap0, cap1;
  logic        prev_bck = 1'b0, prev_le = 1'b0;
  logic [1:0]  prev_data = 2'b00;

  task automatic clear_mon();
    rises = 0; le_rises = 0; le_falls = 0; le_cycles = 0; und_cnt = 0;
    hi_change_err = 0; le_align_err = 0; cont_align_err = 0; per_err = 0;
    gap_max = 0; gap_cnt = 0; gap_armed = 1'b0; freeze = 1'b0; last_rise = -1;
    cap0 = '0; cap1 = '0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (bck && !prev_bck) begin
        if (!freeze) begin
          rises++;
          cap0 = {cap0[62:0], data[0]};
          cap1 = {cap1[62:0], data[1]};
        end
        if (bck_cont && last_rise >= 0 && (cyc - last_rise) != 4) per_err++;
        last_rise = cyc;
        if (gap_armed) begin
          gap_cnt++;
          if (cyc - le_fall_cyc > gap_max) gap_max = cyc - le_fall_cyc;
          gap_armed = 1'b0;
        end
      end
      if (bck && prev_bck && data != prev_data) hi_change_err++;
      if (bck_cont && data != prev_data && !(prev_bck && !bck)) cont_align_err++;
      if (le) le_cycles++;
      if (le && !prev_le) begin
        le_rises++;
        if (!(prev_bck && !bck)) le_align_err++;
        if (freeze_on_le) freeze = 1'b1;
      end
      if (!le && prev_le) begin
        le_falls++;
        le_fall_cyc = cyc;
        gap_armed   = 1'b1;
      end
      if (underrun) und_cnt++;
      prev_bck  = bck;
      prev_le   = le;
      prev_data = data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] c0, input logic [31:0] c1);
    int n = 0;
    while (!fr.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fr.in_ready) chk("push_ready_timeout", 64'(fr.in_ready), 64'd1);
    fr.in_data  = {c1, c0};
    fr.in_valid = 1'b1;
    @(posedge clk); #1;
    fr.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k = 0;
    while (le_falls < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(le_falls), 64'(n));
  endtask

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [4:0]  ob;
    int          len;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] w0[3], w1[3];
  logic [63:0] e0, e1;

  initial begin
    vecs[0] = '{32'hFFFF_FF00, 32'h1234_5678, 5'd0,  24, 64'hFF_FFFF, 64'h12_3456};
    vecs[1] = '{32'hFFFF_FF00, 32'h8000_0001, 5'd31, 24, 64'hFF_FFFF, 64'h80_0000};
    vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 5'd1,  1,  64'h1,       64'h0};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd24, 24, 64'hDE_ADBE, 64'h0F_0F0F};
    vecs[4] = '{32'h0000_0100, 32'hC000_0000, 5'd25, 24, 64'h00_0001, 64'hC0_0000};

    fr.in_valid = 1'b0; fr.in_data = '0;
    out_bits = 5'd16; bck_cont = 1'b0; enable = 1'b1; freeze_on_le = 1'b0;
    resetn = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", 64'(fr.in_ready), 64'd0);
    chk("rst_bck",      64'(bck),         64'd0);
    chk("rst_data",     64'(data),        64'd0);
    chk("rst_le",       64'(le),          64'd0);
    chk("rst_underrun", 64'(underrun),    64'd0);
    chk("rst_level",    64'(fifo_level),  64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(fr.in_ready), 64'd1);

    // Stop-mode latency and the 16-bit reference frame
    clear_mon();
    push(32'hA5A5_0000, 32'h5A5A_FFFF);
    chk("lat_t0_level", 64'(fifo_level), 64'd1);
    chk("lat_t0_data",  64'(data),       64'd0);
    @(posedge clk); #1;
    chk("lat_t1_data",  64'(data),       64'd0);
    chk("lat_t1_bck",   64'(bck),        64'd0);
    @(posedge clk); #1;
    chk("lat_t2_data",  64'(data),       64'b01);
    chk("lat_t2_level", 64'(fifo_level), 64'd0);
    chk("lat_t2_bck",   64'(bck),        64'd0);
    @(posedge clk); #1;
    chk("lat_t3_bck",   64'(bck),        64'd0);
    @(posedge clk); #1;
    chk("lat_t4_bck",   64'(bck),        64'd1);
    wait_frames("ref_done", 1, 300);
    repeat (6) @(posedge clk);
    #1;
    chk("ref_rises",    64'(rises),         64'd16);
    chk("ref_ch0",      cap0,               64'hA5A5);
    chk("ref_ch1",      cap1,               64'h5A5A);
    chk("ref_le_len",   64'(le_cycles),     64'd4);
    chk("ref_le_align", 64'(le_align_err),  64'd0);
    chk("ref_stable",   64'(hi_change_err), 64'd0);
    chk("ref_underrun", 64'(und_cnt),       64'd1);

    // Word-length table
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      out_bits = vecs[i].ob;
      push(vecs[i].c0, vecs[i].c1);
      wait_frames($sformatf("v%0d_done", i), 1, 400);
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("v%0d_rises", i),    64'(rises),         64'(vecs[i].len));
      chk($sformatf("v%0d_ch0", i),      cap0,               vecs[i].e0);
      chk($sformatf("v%0d_ch1", i),      cap1,               vecs[i].e1);
      chk($sformatf("v%0d_le_len", i),   64'(le_cycles),     64'd4);
      chk($sformatf("v%0d_le_align", i), 64'(le_align_err),  64'd0);
      chk($sformatf("v%0d_stable", i),   64'(hi_change_err), 64'd0);
      chk($sformatf("v%0d_underrun", i), 64'(und_cnt),       64'd1);
    end

    // Back-to-back: three queued 18-bit frames
    w0[0] = 32'h1234_5678; w0[1] = 32'h9ABC_DEF0; w0[2] = 32'hCAFE_BABE;
    for (int i = 0; i < 3; i++) w1[i] = ~w0[i];
    enable = 1'b0; out_bits = 5'd18;
    for (int i = 0; i < 3; i++) push(w0[i], w1[i]);
    chk("b2b_level3", 64'(fifo_level), 64'd3);
    clear_mon();
    enable = 1'b1;
    wait_frames("b2b_done", 3, 900);
    repeat (6) @(posedge clk);
    #1;
    e0 = 64'({w0[0][31:14], w0[1][31:14], w0[2][31:14]});
    e1 = 64'({w1[0][31:14], w1[1][31:14], w1[2][31:14]});
    chk("b2b_rises",    64'(rises),      64'd54);
    chk("b2b_ch0",      cap0,            e0);
    chk("b2b_ch1",      cap1,            e1);
    chk("b2b_le_count", 64'(le_rises),   64'd3);
    chk("b2b_gap_cnt",  64'(gap_cnt),    64'd2);
    chk("b2b_gap_max",  64'(gap_max),    64'd3);
    chk("b2b_underrun", 64'(und_cnt),    64'd1);
    chk("b2b_level0",   64'(fifo_level), 64'd0);

    // Full FIFO: the fifth frame must be refused
    enable = 1'b0; out_bits = 5'd8;
    push({8'h11, 24'hABCDEF}, {8'hA1, 24'h000001});
    push({8'h22, 24'hABCDEF}, {8'hA2, 24'h000002});
    push({8'h33, 24'hABCDEF}, {8'hA3, 24'h000003});
    push({8'h44, 24'hABCDEF}, {8'hA4, 24'h000004});
    chk("full_ready",  64'(fr.in_ready), 64'd0);
    chk("full_level",  64'(fifo_level),  64'd4);
    fr.in_data = {32'h5555_5555, 32'h5555_5555};
    fr.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fr.in_valid = 1'b0;
    chk("full_level_hold", 64'(fifo_level),  64'd4);
    chk("full_ready_hold", 64'(fr.in_ready), 64'd0);
    clear_mon();
    enable = 1'b1;
    wait_frames("full_done", 4, 900);
    repeat (6) @(posedge clk);
    #1;
    chk("full_rises",    64'(rises),      64'd32);
    chk("full_ch0",      cap0,            64'h1122_3344);
    chk("full_ch1",      cap1,            64'hA1A2_A3A4);
    chk("full_underrun", 64'(und_cnt),    64'd1);
    chk("full_level0",   64'(fifo_level), 64'd0);

    // Continuous BCK: idle toggling, then a frame aligned to a fall
    bck_cont = 1'b1; out_bits = 5'd16;
    clear_mon();
    freeze_on_le = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("cont_idle_rises", 64'(rises), 64'd5);
    chk("cont_idle_ch0",   cap0,       64'd0);
    chk("cont_idle_ch1",   cap1,       64'd0);
    push(32'hA5A5_0000, 32'h5A5A_FFFF);
    wait_frames("cont_done", 1, 300);
    repeat (8) @(posedge clk);
    #1;
    chk("cont_ch0",      cap0,                64'hA5A5);
    chk("cont_ch1",      cap1,                64'h5A5A);
    chk("cont_period",   64'(per_err),        64'd0);
    chk("cont_align",    64'(cont_align_err), 64'd0);
    chk("cont_le_len",   64'(le_cycles),      64'd4);
    chk("cont_le_align", 64'(le_align_err),   64'd0);
    chk("cont_underrun", 64'(und_cnt),        64'd1);
    bck_cont = 1'b0; freeze_on_le = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-SHIFT with a second frame queued
    out_bits = 5'd24;
    clear_mon();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h1234_5678, 32'h8765_4321);
    begin
      int k = 0;
      while (rises < 5 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("mid_rises5", 64'(rises), 64'd5);
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("mid_bck",      64'(bck),         64'd0);
    chk("mid_data",     64'(data),        64'd0);
    chk("mid_le",       64'(le),          64'd0);
    chk("mid_level",    64'(fifo_level),  64'd0);
    chk("mid_in_ready", 64'(fr.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 64'(fr.in_ready), 64'd1);
    chk("mid_rel_level", 64'(fifo_level),  64'd0);
    chk("mid_no_le",     64'(le_rises),    64'd0);
    clear_mon();
    repeat (40) @(posedge clk);
    #1;
    chk("post_rises",    64'(rises),      64'd0);
    chk("post_le",       64'(le_rises),   64'd0);
    chk("post_underrun", 64'(und_cnt),    64'd0);
    chk("post_level",    64'(fifo_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
